// File: rtl/evt_drain_if.sv
// evt_drain_if: handshake channels of evt_drain (mask in, index out).
//   evt_valid, evt_mask        producer -> drain
//   evt_ready                  drain -> producer
//   idx_valid, idx, idx_last   drain -> consumer
//   idx_ready                  consumer -> drain
interface evt_drain_if #(
    parameter int ELEMENT_NUM = 16,
    parameter int IDX_W       = 4
);
    logic                   evt_valid;
    logic                   evt_ready;
    logic [ELEMENT_NUM-1:0] evt_mask;
    logic                   idx_valid;
    logic                   idx_ready;
    logic [IDX_W-1:0]       idx;
    logic                   idx_last;
    modport master (output evt_valid, evt_mask, idx_ready, input evt_ready, idx_valid, idx, idx_last);
    modport slave  (input evt_valid, evt_mask, idx_ready, output evt_ready, idx_valid, idx, idx_last);
endinterface

// File: rtl/evt_drain.sv
// evt_drain: serialises winner masks into ascending element indices tagged with sort rank.
//   clk, rst   clock, async active-high reset
//   clr        sync clear of used_mask, rank, all_done
//   bus        evt (mask in) and idx (index out) valid/ready channels
//   rank       indices emitted before the current idx since reset/clr
//   used_mask  elements already emitted
//   all_done   sticky, rank reached ELEMENT_NUM
//   err_empty  pulse after accepting a mask with nothing left to emit
module evt_drain #(
    parameter int ELEMENT_NUM = 16,
    parameter int IDX_W       = 4
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   clr,
    evt_drain_if.slave             bus,
    output logic [IDX_W:0]         rank,
    output logic [ELEMENT_NUM-1:0] used_mask,
    output logic                   all_done,
    output logic                   err_empty
);
    typedef enum logic {IDLE, DRAIN} state_t;
    localparam logic [IDX_W:0] RANK_MAX = (IDX_W+1)'(ELEMENT_NUM);
    state_t                 state_q, state_d;
    logic [ELEMENT_NUM-1:0] pend_q, pend_d, used_q, used_d, used_eff, filt, low;
    logic [IDX_W:0]         rank_q, rank_d, rank_eff;
    logic                   done_q, done_d, err_q, err_d;
    logic [IDX_W-1:0]       low_idx;
    // Priority encoder: downward scan leaves the lowest set bit's position.
    always_comb begin
        low_idx = '0;
        for (int i = ELEMENT_NUM - 1; i >= 0; i--) low_idx = pend_q[i] ? IDX_W'(i) : low_idx;
    end
    assign low           = ELEMENT_NUM'(1) << low_idx;
    assign bus.evt_ready = state_q == IDLE;
    assign bus.idx_valid = state_q == DRAIN;
    assign bus.idx       = low_idx;
    assign bus.idx_last  = (state_q == DRAIN) && ((pend_q & (pend_q - ELEMENT_NUM'(1))) == '0);
    assign rank          = rank_q;
    assign used_mask     = used_q;
    assign all_done      = done_q;
    assign err_empty     = err_q;
    // clr is folded in before any handshake update so a same-cycle emission lands on a cleared record.
    always_comb begin
        used_eff = clr ? '0 : used_q;
        rank_eff = clr ? '0 : rank_q;
        filt     = bus.evt_mask & ~used_eff;
        state_d  = state_q;
        pend_d   = pend_q;
        used_d   = used_eff;
        rank_d   = rank_eff;
        done_d   = done_q & ~clr;
        err_d    = 1'b0;
        if (state_q == IDLE) begin
            if (bus.evt_valid) begin
                pend_d  = filt;
                state_d = filt != '0 ? DRAIN : IDLE;
                err_d   = filt == '0;
            end
        end else if (bus.idx_ready) begin
            pend_d  = pend_q & ~low;
            used_d  = used_eff | low;
            rank_d  = rank_eff == RANK_MAX ? rank_eff : rank_eff + (IDX_W+1)'(1);
            done_d  = (done_q & ~clr) | (rank_d == RANK_MAX);
            state_d = bus.idx_last ? IDLE : DRAIN;
        end
    end
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            pend_q  <= '0;
            used_q  <= '0;
            rank_q  <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            pend_q  <= pend_d;
            used_q  <= used_d;
            rank_q  <= rank_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end
endmodule
